fsm_1101_detector: RTL and testbench

FSM_1101_DETECTOR -- requirements
Module: fsm_1101

---
 rtl/fsm_1101_detector.sv | 121 ++++++++++++
 tb/tb_fsm_1101_detector.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_1101_detector.sv
// ----------------------------------------------------------------------------
// fsm_1101_detector
//
// Purpose:
//     Moore state machine that watches a serial bit stream and raises a
//     one-cycle detect flag whenever the sequence 1101 has been received.
//     The first bit of the pattern arrives first. The detect flag comes from
//     the registered state only, so there is no combinational path from the
//     data input to the flag.
//
// Ports:
//     clk    in   1   sole clock; all state updates happen on its rising edge
//     rst_n  in   1   asynchronous, active-low reset (forces S_IDLE, y=0)
//     a      in   1   serial data bit, sampled on each rising clk edge
//     y      out  1   detect flag, high while the FSM sits in S_DET
//
// Configuration:
//     FSM_1101_OVERLAP_EN
//         defined   : S_DET with a=1 goes to S_11. The trailing "1" of a
//                     completed pattern is reused, so 1101101 yields two pulses.
//         undefined : S_DET with a=1 goes to S_1. Matching restarts after
//                     each detection, so 1101101 yields one pulse.
//     Nothing else differs between the two builds.
// ----------------------------------------------------------------------------
module fsm_1101_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic y
);

    // Each state names the longest tail of the stream that is still a prefix
    // of 1101. The encoding is fixed 3-bit binary. Codes 5-7 are unused.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_11   = 3'd2,
        S_110  = 3'd3,
        S_DET  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // State register. Reset is asynchronous, so the FSM returns to S_IDLE as
    // soon as rst_n falls, without waiting for a clock edge. Any partial
    // match is discarded at that point. The first rising edge after release
    // samples a like any other edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. S_11 loops on further ones, so a run such as 1111
    // keeps "11" matched and never reaches S_DET. The detection then needs
    // the 0 followed by a 1. The default branch sends any unused encoding
    // back to S_IDLE.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE: begin
                if (a) begin
                    next_state = S_1;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_1: begin
                if (a) begin
                    next_state = S_11;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_11: begin
                if (a) begin
                    next_state = S_11;
                end else begin
                    next_state = S_110;
                end
            end
            S_110: begin
                if (a) begin
                    next_state = S_DET;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_DET: begin
                if (a) begin
`ifdef FSM_1101_OVERLAP_EN
                    // The final 1 of 1101 plus this 1 already form "11".
                    next_state = S_11;
`else
                    // Only this fresh 1 counts toward the next pattern.
                    next_state = S_1;
`endif
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Moore output. The flag depends on the registered state only, so it
    // goes high on the same edge that samples the final 1 of the pattern.
    // Unused encodings decode to 0.
    always_comb begin
        y = 1'b0;
        if (state == S_DET) begin
            y = 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm_1101_detector.sv
// ----------------------------------------------------------------------------
// tb_fsm_1101_detector
//
// Self-checking bench for fsm_1101_detector. The expected detect flag for
// every driven bit comes from a reference that searches the received bit
// history for 1101 and pushes its answer onto a scoreboard queue. The answer
// is popped and compared once the DUT has clocked that bit in.
// Build with FSM_1101_OVERLAP_EN defined to check the overlapping variant.
// ----------------------------------------------------------------------------
module tb_fsm_1101_detector;

    logic clk;
    logic rst_n;
    logic a;
    logic y;

`ifdef FSM_1101_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    int checks;
    int passed;

    // Scoreboard of expected y values, one entry per driven bit.
    bit exp_q[$];

    // Bits received since reset, or since the last detection in the
    // non-overlapping build. The queue is trimmed to the last four bits.
    bit hist[$];

    fsm_1101_detector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .y     (y)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a detection occurs when the most recent four bits are
    // 1,1,0,1. In the non-overlapping build, the bits of a detected pattern
    // cannot take part in a later detection, so the history is cleared.
    function automatic bit model_step(input bit b);
        bit det;
        det = 1'b0;
        hist.push_back(b);
        if (hist.size() > 4) begin
            void'(hist.pop_front());
        end
        if (hist.size() == 4) begin
            if (hist[0] && hist[1] && !hist[2] && hist[3]) begin
                det = 1'b1;
            end
        end
        if (det && !OVERLAP) begin
            hist.delete();
        end
        return det;
    endfunction

    // Drive one bit on the falling edge, away from the sampling edge, and
    // record the reference answer for it.
    task automatic applyStimulus(input bit b);
        @(negedge clk);
        a = b;
        exp_q.push_back(model_step(b));
    endtask

    // Reset held for 10 ns, then five idle cycles.
    task automatic test_reset();
        bit e;
        rst_n = 1'b0;
        a     = 1'b0;
        hist.delete();
        #10;
        checks++;
        if (y !== 1'b0) begin
            $display("[TB] FAIL reset_hold: y=%b expected=0", y);
        end else begin
            passed++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (y !== e) begin
                $display("[TB] FAIL reset_idle[%0d]: y=%b expected=%b", i, y, e);
            end else begin
                passed++;
            end
        end
    endtask

    // Basic 1101, followed by a 0 to show the pulse lasts exactly one cycle.
    task automatic test_basic();
        bit bits[5];
        bit e;
        bits = '{1, 1, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(bits[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (y !== e) begin
                $display("[TB] FAIL basic_1101[%0d]: y=%b expected=%b", i, y, e);
            end else begin
                passed++;
            end
        end
    endtask

    // Five idle cycles, then a run of ones. The run must never assert y.
    task automatic test_run_of_ones();
        bit bits[9];
        bit e;
        bits = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(bits[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (y !== e) begin
                $display("[TB] FAIL ones_run[%0d]: y=%b expected=%b", i, y, e);
            end else begin
                passed++;
            end
        end
    endtask

    // Send 1101101. The overlapping build must give two pulses, three cycles
    // apart. The non-overlapping build must give one pulse, after bit 4.
    task automatic test_overlap();
        bit bits[10];
        bit e;
        int pulses;
        int first_at;
        int last_at;
        int exp_pulses;
        int exp_last;
        bits = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 1};
        pulses   = 0;
        first_at = -1;
        last_at  = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(bits[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (y !== e) begin
                $display("[TB] FAIL overlap_seq[%0d]: y=%b expected=%b", i, y, e);
            end else begin
                passed++;
            end
            if (y === 1'b1) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = i;
                end
                last_at = i;
            end
        end
        exp_pulses = OVERLAP ? 2 : 1;
        exp_last   = OVERLAP ? 9 : 6;
        checks++;
        if (pulses != exp_pulses) begin
            $display("[TB] FAIL overlap_count: pulses=%0d expected=%0d", pulses, exp_pulses);
        end else begin
            passed++;
        end
        checks++;
        if (first_at != 6 || last_at != exp_last) begin
            $display("[TB] FAIL overlap_position: first=%0d last=%0d expected first=6 last=%0d",
                     first_at, last_at, exp_last);
        end else begin
            passed++;
        end
    endtask

    // Two patterns sent back to back (11011101) must give two pulses in both
    // builds.
    task automatic test_back_to_back();
        bit bits[10];
        bit e;
        bits = '{0, 0, 1, 1, 0, 1, 1, 1, 0, 1};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(bits[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (y !== e) begin
                $display("[TB] FAIL back_to_back[%0d]: y=%b expected=%b", i, y, e);
            end else begin
                passed++;
            end
        end
    endtask

    // Send 110, then assert reset between clock edges and hold it across an
    // edge. After release, a single 1 must not trigger a detection. A full
    // 1101 after that must still be detected.
    task automatic test_mid_reset();
        bit pre[5];
        bit post[4];
        bit e;
        pre  = '{0, 0, 1, 1, 0};
        post = '{1, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(pre[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (y !== e) begin
                $display("[TB] FAIL pre_reset[%0d]: y=%b expected=%b", i, y, e);
            end else begin
                passed++;
            end
        end
        #2;
        rst_n = 1'b0;
        hist.delete();
        #1;
        checks++;
        if (y !== 1'b0) begin
            $display("[TB] FAIL async_reset: y=%b expected=0", y);
        end else begin
            passed++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (y !== 1'b0) begin
            $display("[TB] FAIL reset_across_edge: y=%b expected=0", y);
        end else begin
            passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(post[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (y !== e) begin
                $display("[TB] FAIL post_reset[%0d]: y=%b expected=%b", i, y, e);
            end else begin
                passed++;
            end
        end
    endtask

    // Send 11101. The run of ones stays matched in S_11, and y pulses after
    // the fifth bit.
    task automatic test_long_prefix();
        bit bits[8];
        bit e;
        bits = '{0, 0, 0, 1, 1, 1, 0, 1};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(bits[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (y !== e) begin
                $display("[TB] FAIL long_prefix[%0d]: y=%b expected=%b", i, y, e);
            end else begin
                passed++;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end else begin
            passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        a      = 1'b0;
        rst_n  = 1'b0;
        test_reset();
        test_basic();
        test_run_of_ones();
        test_overlap();
        test_back_to_back();
        test_mid_reset();
        test_long_prefix();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
